counter_comparator: RTL and testbench

Free-running modulo counter with an integrated magnitude comparator, used as the building block of the VGA timing generator. One instance serves as the horizontal pixel counter. A second instance, enabled by the first one's `wrap` pulse, serves as the line counter. The comparator outputs drive sync and blanking decode.

---
 rtl/counter_comparator.sv | 127 ++++++++++++
 tb/tb_counter_comparator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_comparator.sv
// counter_comparator: free-running modulo counter with a magnitude comparator.
// It is the building block of the VGA timing generator and is cascaded via wrap.
// Optional macro COUNTER_COMPARATOR_REG_OUT_EN registers lt/eq/gt/wrap.

// Unsigned magnitude comparator, purely combinational.
module counter_comparator_cmp #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt_c,
  output logic             eq_c,
  output logic             gt_c
);

  // Exactly one of the three flags is high for any operand pair.
  always_comb begin
    lt_c = (a < b);
    eq_c = (a == b);
    gt_c = (a > b);
  end

endmodule

module counter_comparator #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TERMINAL = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] cmp_b,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_d;
  logic             term_lt_c;
  logic             term_eq_c;
  logic             term_gt_c;
  logic             lt_c;
  logic             eq_c;
  logic             gt_c;
  logic             wrap_c;

  // Terminal detect against the constant last count value.
  counter_comparator_cmp #(.WIDTH(WIDTH)) u_term_cmp (
    .a    (count),
    .b    (TERM_VAL),
    .lt_c (term_lt_c),
    .eq_c (term_eq_c),
    .gt_c (term_gt_c)
  );

  // Threshold compare against the external operand.
  counter_comparator_cmp #(.WIDTH(WIDTH)) u_thr_cmp (
    .a    (count),
    .b    (cmp_b),
    .lt_c (lt_c),
    .eq_c (eq_c),
    .gt_c (gt_c)
  );

  // Cascade enable: terminal reached, counting, and not being cleared.
  always_comb begin
    wrap_c = en & ~clr & term_eq_c;
  end

  // Next count: clear beats enable; any value at or past terminal reloads 0.
  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (term_eq_c || term_gt_c) begin
        count_d = '0;
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

`ifdef COUNTER_COMPARATOR_REG_OUT_EN
  // Registered flags, one cycle behind the values they reflect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt   <= 1'b1;
      eq   <= 1'b0;
      gt   <= 1'b0;
      wrap <= 1'b0;
    end else begin
      lt   <= lt_c;
      eq   <= eq_c;
      gt   <= gt_c;
      wrap <= wrap_c;
    end
  end
  logic unused_term_lt;
  assign unused_term_lt = term_lt_c;
`else
  // Zero-latency flags straight from the comparators.
  always_comb begin
    lt   = lt_c;
    eq   = eq_c;
    gt   = gt_c;
    wrap = wrap_c;
  end
  logic unused_term_lt;
  assign unused_term_lt = term_lt_c;
`endif

endmodule

// File: tb/tb_counter_comparator.sv
// Directed bench for counter_comparator: reset, wrap, compare, enable/clear, cascade.
module tb_counter_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [9:0] cmp_b;
  logic [9:0] h_count;
  logic       h_wrap, h_lt, h_eq, h_gt;
  logic [9:0] v_count;
  logic       v_wrap, v_lt, v_eq, v_gt;
  logic       s_en;
  logic [3:0] sh_count;
  logic       sh_wrap, sh_lt, sh_eq, sh_gt;
  logic [2:0] sv_count;
  logic       sv_wrap, sv_lt, sv_eq, sv_gt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_comparator #(.WIDTH(10), .TERMINAL(799)) u_h (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cmp_b(cmp_b),
    .count(h_count), .wrap(h_wrap), .lt(h_lt), .eq(h_eq), .gt(h_gt));

  counter_comparator #(.WIDTH(10), .TERMINAL(524)) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_wrap), .clr(clr), .cmp_b(10'd0),
    .count(v_count), .wrap(v_wrap), .lt(v_lt), .eq(v_eq), .gt(v_gt));

  counter_comparator #(.WIDTH(4), .TERMINAL(9)) u_sh (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clr(clr), .cmp_b(4'd0),
    .count(sh_count), .wrap(sh_wrap), .lt(sh_lt), .eq(sh_eq), .gt(sh_gt));

  counter_comparator #(.WIDTH(3), .TERMINAL(4)) u_sv (
    .clk(clk), .rst_n(rst_n), .en(sh_wrap), .clr(clr), .cmp_b(3'd0),
    .count(sv_count), .wrap(sv_wrap), .lt(sv_lt), .eq(sv_eq), .gt(sv_gt));

  // Synchronous clear of every counter, leaving en as given.
  task automatic do_clear(input logic en_after);
    clr = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en  = en_after;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; cmp_b = 10'd5; s_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (h_count !== 10'd0 || h_wrap !== 1'b0) begin
      fails++; $display("FAIL reset_count: count=%0d wrap=%b, want 0/0", h_count, h_wrap);
    end
    tests++;
    if ({h_lt, h_eq, h_gt} !== 3'b100) begin
      fails++; $display("FAIL reset_flags_b5: ltegt=%b, want 100", {h_lt, h_eq, h_gt});
    end
`ifndef COUNTER_COMPARATOR_REG_OUT_EN
    cmp_b = 10'd0;
    #1;
    tests++;
    if ({h_lt, h_eq, h_gt} !== 3'b010) begin
      fails++; $display("FAIL reset_flags_b0: ltegt=%b, want 010", {h_lt, h_eq, h_gt});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    repeat (37) @(negedge clk);
    tests++;
    if (h_count !== 10'd37) begin
      fails++; $display("FAIL pre_reset_count: count=%0d, want 37", h_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (h_count !== 10'd0) begin
      fails++; $display("FAIL async_reset: count=%0d, want 0 before edge", h_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (h_count !== 10'(k)) begin
        fails++; $display("FAIL restart_%0d: count=%0d, want %0d", k, h_count, k);
      end
    end
  endtask

`ifndef COUNTER_COMPARATOR_REG_OUT_EN
  task automatic test_wrap();
    int n;
    do_clear(1'b1);
    repeat (798) @(negedge clk);
    tests++;
    if (h_count !== 10'd798 || h_wrap !== 1'b0) begin
      fails++; $display("FAIL wrap_798: count=%0d wrap=%b, want 798/0", h_count, h_wrap);
    end
    @(negedge clk);
    tests++;
    if (h_count !== 10'd799 || h_wrap !== 1'b1) begin
      fails++; $display("FAIL wrap_799: count=%0d wrap=%b, want 799/1", h_count, h_wrap);
    end
    @(negedge clk);
    tests++;
    if (h_count !== 10'd0 || h_wrap !== 1'b0) begin
      fails++; $display("FAIL wrap_0: count=%0d wrap=%b, want 0/0", h_count, h_wrap);
    end
    n = 0;
    while (h_wrap !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n + 1 != 800) begin
      fails++; $display("FAIL wrap_period: period=%0d, want 800", n + 1);
    end
  endtask

  task automatic test_compare();
    int bad = 0;
    cmp_b = 10'd94;
    do_clear(1'b1);
    for (int i = 0; i < 800; i++) begin
      tests++;
      if (h_count !== 10'(i) || h_lt !== (i < 94) || h_eq !== (i == 94) || h_gt !== (i > 94)
          || h_wrap !== (i == 799)) begin
        fails++;
        if (bad < 5) $display("FAIL cmp_sweep_%0d: count=%0d lt=%b eq=%b gt=%b wrap=%b",
                              i, h_count, h_lt, h_eq, h_gt, h_wrap);
        bad++;
      end
      @(negedge clk);
    end
    en = 1'b0;
    cmp_b = 10'd0;
    #1;
    tests++;
    if ({h_lt, h_eq, h_gt} !== 3'b010) begin
      fails++; $display("FAIL cmp_follow_b0: ltegt=%b, want 010", {h_lt, h_eq, h_gt});
    end
    do_clear(1'b1);
    repeat (799) @(negedge clk);
    en = 1'b0;
    cmp_b = 10'd1023;
    #1;
    tests++;
    if ({h_lt, h_eq, h_gt} !== 3'b100 || h_wrap !== 1'b0) begin
      fails++; $display("FAIL cmp_b_max: ltegt=%b wrap=%b, want 100/0", {h_lt, h_eq, h_gt}, h_wrap);
    end
    cmp_b = 10'd0;
    #1;
    tests++;
    if ({h_lt, h_eq, h_gt} !== 3'b001) begin
      fails++; $display("FAIL cmp_b_min: ltegt=%b, want 001", {h_lt, h_eq, h_gt});
    end
  endtask

  task automatic test_enable_clear();
    do_clear(1'b1);
    repeat (100) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (h_count !== 10'd100) begin
        fails++; $display("FAIL hold_%0d: count=%0d, want 100", k, h_count);
      end
    end
    en = 1'b1;
    repeat (699) @(negedge clk);
    tests++;
    if (h_count !== 10'd799 || h_wrap !== 1'b1) begin
      fails++; $display("FAIL pre_clr: count=%0d wrap=%b, want 799/1", h_count, h_wrap);
    end
    clr = 1'b1;
    #1;
    tests++;
    if (h_wrap !== 1'b0) begin
      fails++; $display("FAIL clr_wrap: wrap=%b, want 0", h_wrap);
    end
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (h_count !== 10'd0 || v_count !== 10'd0) begin
      fails++; $display("FAIL clr_count: h=%0d v=%0d, want 0/0", h_count, v_count);
    end
  endtask

  task automatic test_cascade();
    do_clear(1'b1);
    for (int line = 1; line <= 3; line++) begin
      repeat (799) @(negedge clk);
      tests++;
      if (h_count !== 10'd799 || v_count !== 10'(line - 1)) begin
        fails++; $display("FAIL casc_pre_%0d: h=%0d v=%0d, want 799/%0d", line, h_count, v_count, line - 1);
      end
      @(negedge clk);
      tests++;
      if (h_count !== 10'd0 || v_count !== 10'(line)) begin
        fails++; $display("FAIL casc_step_%0d: h=%0d v=%0d, want 0/%0d", line, h_count, v_count, line);
      end
    end
    en = 1'b0;
    s_en = 1'b1;
    do_clear(1'b0);
    repeat (10) @(negedge clk);
    tests++;
    if (sh_count !== 4'd0 || sv_count !== 3'd1) begin
      fails++; $display("FAIL small_line: h=%0d v=%0d, want 0/1", sh_count, sv_count);
    end
    repeat (39) @(negedge clk);
    tests++;
    if (sh_count !== 4'd9 || sv_count !== 3'd4 || sh_wrap !== 1'b1) begin
      fails++; $display("FAIL small_last: h=%0d v=%0d hw=%b, want 9/4/1", sh_count, sv_count, sh_wrap);
    end
    @(negedge clk);
    tests++;
    if (sh_count !== 4'd0 || sv_count !== 3'd0) begin
      fails++; $display("FAIL small_frame: h=%0d v=%0d, want 0/0", sh_count, sv_count);
    end
    s_en = 1'b0;
  endtask
`else
  task automatic test_reg_out();
    cmp_b = 10'd10;
    do_clear(1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (h_count !== 10'd10 || h_eq !== 1'b0 || h_lt !== 1'b1) begin
      fails++; $display("FAIL reg_same: count=%0d eq=%b lt=%b, want 10/0/1", h_count, h_eq, h_lt);
    end
    @(negedge clk);
    tests++;
    if (h_count !== 10'd11 || h_eq !== 1'b1) begin
      fails++; $display("FAIL reg_next: count=%0d eq=%b, want 11/1", h_count, h_eq);
    end
    @(negedge clk);
    tests++;
    if (h_eq !== 1'b0 || h_gt !== 1'b1) begin
      fails++; $display("FAIL reg_after: eq=%b gt=%b, want 0/1", h_eq, h_gt);
    end
    repeat (788) @(negedge clk);
    tests++;
    if (h_count !== 10'd0 || h_wrap !== 1'b1) begin
      fails++; $display("FAIL reg_wrap: count=%0d wrap=%b, want 0/1", h_count, h_wrap);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef COUNTER_COMPARATOR_REG_OUT_EN
    test_wrap();
    test_compare();
    test_enable_clear();
    test_cascade();
`else
    test_reg_out();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
